// File: rtl/joy_poll_sched.sv
// Round-robin poller for two PmodJSTK joysticks sharing one SPI byte engine.
// Define JOY_DEADZONE_EN to snap near-centre axis samples to 512.
module joy_poll_sched #(
  parameter int POLL_DIV = 50000,
  parameter int SETTLE   = 1500,
  parameter int TIMEOUT  = 4095,
  parameter int DZ       = 40
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] en,
  input  logic [1:0] led1,
  input  logic [1:0] led2,
  output logic       byte_req,
  output logic [7:0] byte_tx,
  input  logic       byte_done,
  input  logic [7:0] byte_rx,
  output logic [1:0] ss_n,
  output logic [9:0] joy1_x,
  output logic [9:0] joy1_y,
  output logic [9:0] joy2_x,
  output logic [9:0] joy2_y,
  output logic [2:0] btn1,
  output logic [2:0] btn2,
  output logic [1:0] cursor_tick,
  output logic [1:0] err,
  output logic       busy
);

  localparam int PW   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [9:0] DZ_LO = 10'(512 - DZ);
  localparam logic [9:0] DZ_HI = 10'(512 + DZ);
`ifdef JOY_DEADZONE_EN
  localparam bit DZ_ON = 1'b1;
`else
  localparam bit DZ_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_REQ, ST_WAIT, ST_GAP, ST_DONE, ST_ABORT
  } state_t;

  state_t        state_r, state_s;
  logic          sel_r, sel_s;
  logic          rr_r, rr_s;
  logic [2:0]    k_r, k_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [PW-1:0] poll_r;
  logic [7:0]    sh0_r, sh2_r;
  logic [1:0]    sh1_r, sh3_r;
  logic          slot_s, err_set_s, shadow_we_s, active_s, done_s;
  logic [1:0]    led_sel_s;
  logic [9:0]    x_s, y_s;

  function automatic logic [9:0] dz_filter(input logic [9:0] v);
    logic in_zone;
    in_zone = (v >= DZ_LO) && (v <= DZ_HI);
    if (DZ_ON && in_zone) begin
      dz_filter = 10'd512;
    end else begin
      dz_filter = v;
    end
  endfunction

  assign slot_s    = (poll_r == PW'(POLL_DIV - 1));
  assign active_s  = state_s inside {ST_SEL, ST_REQ, ST_WAIT, ST_GAP};
  assign done_s    = (state_s == ST_DONE);
  assign led_sel_s = sel_s ? led2 : led1;
  assign x_s       = dz_filter({sh1_r, sh0_r});
  assign y_s       = dz_filter({sh3_r, sh2_r});

  // Next-state logic for the 5-byte transaction sequencer and arbiter.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    rr_s        = rr_r;
    k_s         = k_r;
    cnt_s       = cnt_r;
    err_set_s   = 1'b0;
    shadow_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (slot_s && en[rr_r]) begin
          sel_s   = rr_r;
          rr_s    = ~rr_r;
          k_s     = 3'd0;
          cnt_s   = '0;
          state_s = ST_SEL;
        end else if (slot_s && en[~rr_r]) begin
          sel_s   = ~rr_r;
          rr_s    = rr_r;
          k_s     = 3'd0;
          cnt_s   = '0;
          state_s = ST_SEL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEL, ST_GAP: begin
        if (cnt_r == CW'(SETTLE - 1)) begin
          cnt_s   = '0;
          state_s = ST_REQ;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_REQ: begin
        cnt_s   = '0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_done) begin
          if (k_r == 3'd4) begin
            state_s = ST_DONE;
          end else begin
            shadow_we_s = 1'b1;
            k_s         = k_r + 3'd1;
            cnt_s       = '0;
            state_s     = ST_GAP;
          end
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          err_set_s = 1'b1;
          state_s   = ST_ABORT;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DONE, ST_ABORT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, poll counter and shadow byte registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 1'b0;
      rr_r    <= 1'b0;
      k_r     <= 3'd0;
      cnt_r   <= '0;
      poll_r  <= '0;
      sh0_r   <= 8'd0;
      sh1_r   <= 2'd0;
      sh2_r   <= 8'd0;
      sh3_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      rr_r    <= rr_s;
      k_r     <= k_s;
      cnt_r   <= cnt_s;
      poll_r  <= slot_s ? '0 : poll_r + PW'(1);
      if (shadow_we_s) begin
        case (k_r[1:0])
          2'd0:    sh0_r <= byte_rx;
          2'd1:    sh1_r <= byte_rx[1:0];
          2'd2:    sh2_r <= byte_rx;
          2'd3:    sh3_r <= byte_rx[1:0];
          default: sh0_r <= sh0_r;
        endcase
      end
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ss_n        <= 2'b11;
      byte_req    <= 1'b0;
      byte_tx     <= 8'h00;
      joy1_x      <= 10'd512;
      joy1_y      <= 10'd512;
      joy2_x      <= 10'd512;
      joy2_y      <= 10'd512;
      btn1        <= 3'd0;
      btn2        <= 3'd0;
      cursor_tick <= 2'b00;
      err         <= 2'b00;
      busy        <= 1'b0;
    end else begin
      ss_n        <= active_s ? (sel_s ? 2'b01 : 2'b10) : 2'b11;
      byte_req    <= (state_s == ST_REQ);
      byte_tx     <= (state_s == ST_REQ && k_s == 3'd0) ? {6'b100000, led_sel_s} : 8'h00;
      cursor_tick <= done_s ? (sel_s ? 2'b10 : 2'b01) : 2'b00;
      busy        <= (state_s != ST_IDLE);
      if (err_set_s) begin
        err <= err | (sel_r ? 2'b10 : 2'b01);
      end else begin
        err <= err;
      end
      if (done_s && !sel_r) begin
        joy1_x <= x_s;
        joy1_y <= y_s;
        btn1   <= byte_rx[2:0];
      end else if (done_s && sel_r) begin
        joy2_x <= x_s;
        joy2_y <= y_s;
        btn2   <= byte_rx[2:0];
      end else begin
        joy1_x <= joy1_x;
        joy2_x <= joy2_x;
      end
    end
  end

endmodule

// File: tb/tb_joy_poll_sched.sv
// Directed bench for joy_poll_sched: byte engine model plus hand-computed expectations.
module tb_joy_poll_sched;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] en, led1, led2;
  logic       byte_req, byte_done;
  logic [7:0] byte_tx, byte_rx;
  logic [1:0] ss_n, cursor_tick, err;
  logic [9:0] joy1_x, joy1_y, joy2_x, joy2_y;
  logic [2:0] btn1, btn2;
  logic       busy;

  logic [1:0] en2;
  logic       byte_req2, byte_done2, busy2;
  logic [7:0] byte_tx2, byte_rx2;
  logic [1:0] ss_n2, tick2, err2;
  logic [9:0] j1x2, j1y2, j2x2, j2y2;
  logic [2:0] b12, b22;

  int n_checks = 0;
  int n_errors = 0;
  int tick_p1 = 0, tick_p2 = 0, t2a = 0, t2b = 0, ss_bad = 0;
  logic suppress = 1'b0;
  logic [7:0] p1_resp [5];
  logic [7:0] p2_resp [5];
  logic [7:0] tx_log [$];
  logic [1:0] t;
  int eng_k;

  always #5 clk = ~clk;

  joy_poll_sched #(.POLL_DIV(80), .SETTLE(4), .TIMEOUT(40), .DZ(40)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .led1(led1), .led2(led2),
    .byte_req(byte_req), .byte_tx(byte_tx), .byte_done(byte_done), .byte_rx(byte_rx),
    .ss_n(ss_n), .joy1_x(joy1_x), .joy1_y(joy1_y), .joy2_x(joy2_x), .joy2_y(joy2_y),
    .btn1(btn1), .btn2(btn2), .cursor_tick(cursor_tick), .err(err), .busy(busy)
  );

  joy_poll_sched #(.POLL_DIV(16), .SETTLE(2), .TIMEOUT(40), .DZ(40)) dut_fast (
    .clk(clk), .clr_n(clr_n), .en(en2), .led1(2'b00), .led2(2'b00),
    .byte_req(byte_req2), .byte_tx(byte_tx2), .byte_done(byte_done2), .byte_rx(byte_rx2),
    .ss_n(ss_n2), .joy1_x(j1x2), .joy1_y(j1y2), .joy2_x(j2x2), .joy2_y(j2y2),
    .btn1(b12), .btn2(b22), .cursor_tick(tick2), .err(err2), .busy(busy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (busy === lvl) seen = 1'b1;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_tick(input int budget, output logic [1:0] tk);
    tk = 2'b00;
    for (int i = 0; i < budget && tk == 2'b00; i++) begin
      @(posedge clk); #1;
      if (cursor_tick !== 2'b00) tk = cursor_tick;
    end
  endtask

  // SPI byte engine model for the main DUT: fixed latency, per-player reply tables.
  initial begin
    byte_done = 1'b0;
    byte_rx   = 8'h00;
    eng_k     = 0;
    forever begin
      @(posedge clk); #1;
      if (byte_req === 1'b1) begin
        tx_log.push_back(byte_tx);
        if (byte_tx[7]) eng_k = 0;
        if (!(suppress && eng_k == 2)) begin
          repeat (2) @(posedge clk);
          #1;
          byte_rx   = (ss_n == 2'b01) ? p2_resp[eng_k % 5] : p1_resp[eng_k % 5];
          byte_done = 1'b1;
          @(posedge clk); #1;
          byte_done = 1'b0;
        end
        eng_k++;
      end
    end
  end

  // Byte engine model for the short-slot DUT.
  initial begin
    byte_done2 = 1'b0;
    byte_rx2   = 8'h11;
    forever begin
      @(posedge clk); #1;
      if (byte_req2 === 1'b1) begin
        repeat (2) @(posedge clk);
        #1;
        byte_done2 = 1'b1;
        @(posedge clk); #1;
        byte_done2 = 1'b0;
      end
    end
  end

  // Monitors: one-hot select and tick counts.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ss_n === 2'b00) ss_bad++;
      if (ss_n2 === 2'b00) ss_bad++;
      tick_p1 += int'(cursor_tick[0]);
      tick_p2 += int'(cursor_tick[1]);
      t2a     += int'(tick2[0]);
      t2b     += int'(tick2[1]);
    end
  end

  initial begin
    int nreq, tp1_before;
    clr_n = 1'b0; en = 2'b00; en2 = 2'b00; led1 = 2'b10; led2 = 2'b01;
    p1_resp[0] = 8'h34; p1_resp[1] = 8'h02; p1_resp[2] = 8'hC8; p1_resp[3] = 8'h01; p1_resp[4] = 8'h05;
    p2_resp[0] = 8'h10; p2_resp[1] = 8'h01; p2_resp[2] = 8'h20; p2_resp[3] = 8'h03; p2_resp[4] = 8'h02;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_ss_n", {30'd0, ss_n}, 32'h3);
    check_eq("rst_req", {31'd0, byte_req}, 32'h0);
    check_eq("rst_tx", {24'd0, byte_tx}, 32'h0);
    check_eq("rst_joy1_x", {22'd0, joy1_x}, 32'd512);
    check_eq("rst_joy2_y", {22'd0, joy2_y}, 32'd512);
    check_eq("rst_btn1", {29'd0, btn1}, 32'h0);
    check_eq("rst_tick", {30'd0, cursor_tick}, 32'h0);
    check_eq("rst_err", {30'd0, err}, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);

    // First transaction to P1
    clr_n = 1'b1; en = 2'b11;
    tx_log.delete();
    wait_busy(1'b1, 200, "p1_start");
    check_eq("p1_ss_n", {30'd0, ss_n}, 32'h2);
    wait_tick(200, t);
    check_eq("p1_tick", {30'd0, t}, 32'h1);
    check_eq("p1_done_ss_n", {30'd0, ss_n}, 32'h3);
    check_eq("joy1_x", {22'd0, joy1_x}, 32'h234);
    check_eq("joy1_y", {22'd0, joy1_y}, 32'h1C8);
    check_eq("btn1", {29'd0, btn1}, 32'h5);
    check_eq("joy2_x_hold", {22'd0, joy2_x}, 32'd512);
    check_eq("tx_count", tx_log.size(), 32'd5);
    if (tx_log.size() == 5) begin
      check_eq("tx0", {24'd0, tx_log[0]}, 32'h82);
      for (int i = 1; i < 5; i++) check_eq("txn", {24'd0, tx_log[i]}, 32'h0);
    end
    @(posedge clk); #1;
    check_eq("tick_one_cycle", {30'd0, cursor_tick}, 32'h0);
    check_eq("tick_p1_count", tick_p1, 32'd1);

    // Round-robin P2, P1, P2
    wait_tick(200, t);
    check_eq("rr_2", {30'd0, t}, 32'h2);
    check_eq("joy2_x", {22'd0, joy2_x}, 32'h110);
    check_eq("joy2_y", {22'd0, joy2_y}, 32'h320);
    check_eq("btn2", {29'd0, btn2}, 32'h2);
    wait_tick(200, t);
    check_eq("rr_3", {30'd0, t}, 32'h1);
    wait_tick(200, t);
    check_eq("rr_4", {30'd0, t}, 32'h2);

    // Only P2 enabled
    en = 2'b10;
    wait_tick(200, t);
    check_eq("en10_a", {30'd0, t}, 32'h2);
    wait_tick(200, t);
    check_eq("en10_b", {30'd0, t}, 32'h2);

    // Timeout on byte 2 for P1
    en = 2'b11; suppress = 1'b1;
    tp1_before = tick_p1;
    wait_busy(1'b1, 200, "to_start");
    wait_busy(1'b0, 200, "to_end");
    check_eq("to_err", {30'd0, err}, 32'h1);
    check_eq("to_ss_n", {30'd0, ss_n}, 32'h3);
    check_eq("to_no_tick", tick_p1, tp1_before);
    check_eq("to_joy1_x", {22'd0, joy1_x}, 32'h234);
    check_eq("to_joy1_y", {22'd0, joy1_y}, 32'h1C8);
    suppress = 1'b0;
    wait_tick(200, t);
    check_eq("to_next_p2", {30'd0, t}, 32'h2);

    // Reset during WAIT of byte 3 (P1)
    wait_busy(1'b1, 200, "rst_mid_start");
    nreq = 0;
    for (int i = 0; i < 200 && nreq < 4; i++) begin
      @(posedge clk); #1;
      if (byte_req === 1'b1) nreq++;
    end
    check_eq("rst_mid_reqs", nreq, 32'd4);
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    check_eq("rst_mid_ss_n", {30'd0, ss_n}, 32'h3);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'h0);
    check_eq("rst_mid_joy1", {22'd0, joy1_x}, 32'd512);
    check_eq("rst_mid_err", {30'd0, err}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    clr_n = 1'b1;
    wait_tick(200, t);
    check_eq("rst_mid_first_p1", {30'd0, t}, 32'h1);
    check_eq("rst_mid_joy1_x", {22'd0, joy1_x}, 32'h234);

    // Near-centre sample: x=540, y=553
    en = 2'b01;
    p1_resp[0] = 8'h1C; p1_resp[1] = 8'h02; p1_resp[2] = 8'h29; p1_resp[3] = 8'h02; p1_resp[4] = 8'h00;
    wait_tick(200, t);
    check_eq("dz_tick", {30'd0, t}, 32'h1);
`ifdef JOY_DEADZONE_EN
    check_eq("dz_x540", {22'd0, joy1_x}, 32'd512);
`else
    check_eq("dz_x540", {22'd0, joy1_x}, 32'd540);
`endif
    check_eq("dz_y553", {22'd0, joy1_y}, 32'd553);

    // Slots shorter than a transaction: 25 slots, each transaction spans at least two
    en2 = 2'b11;
    repeat (400) @(posedge clk);
    #2;
    check_eq("fast_some", {31'd0, (t2a + t2b) >= 5}, 32'h1);
    check_eq("fast_dropped", {31'd0, (t2a + t2b) <= 13}, 32'h1);
    check_eq("fast_alternate", {31'd0, (t2a - t2b) <= 1 && (t2b - t2a) <= 1}, 32'h1);
    check_eq("fast_err", {30'd0, err2}, 32'h0);
    check_eq("ss_onehot", ss_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/joy_poll_sched.md
Name: joy_poll_sched

Overview:
- Polls two PmodJSTK joysticks over one shared SPI byte engine.
- Sequences the 5-byte read transaction and arbitrates the engine round-robin between player 1 and player 2.
- Latches 10-bit X/Y and the button bits per player.
- Emits a one-cycle cursor_tick per player. The cursor-update blocks consume these ticks in place of a free-running cursor clock, with edge detection unchanged.

Parameters:
- POLL_DIV, 50000: clk cycles between poll slots; one player is served per slot.
- SETTLE, 1500: cycles between ss_n assert and the first byte, and between bytes.
- TIMEOUT, 4095: maximum cycles to wait for byte_done before aborting.
- DZ, 40: deadzone half-width; used only with JOY_DEADZONE_EN.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- en  in  2  per-player poll enable; bit0 = P1, bit1 = P2.
- led1, led2  in  2 each  LED bits sent in byte 0 for that player.
- byte_req  out  1  one-cycle pulse; the SPI engine starts a byte.
- byte_tx  out  8  byte to shift out; valid while byte_req is high.
- byte_done  in  1  one-cycle pulse; byte_rx is valid.
- byte_rx  in  8  received byte.
- ss_n  out  2  per-joystick slave select, active low.
- joy1_x, joy1_y, joy2_x, joy2_y  out  10 each  latched axis values.
- btn1, btn2  out  3 each  latched buttons {trigger, jbtn1, jbtn0}.
- cursor_tick  out  2  one-cycle pulse per player on a fresh sample.
- err  out  2  sticky per-player timeout flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clr_n=0, async), all outputs and state:
  - State IDLE; poll counter 0; rr pointer = P1.
  - ss_n=2'b11, byte_req=0, byte_tx=0.
  - joy*_x and joy*_y = 512 (stick centre, so no cursor motion); btn*=0.
  - cursor_tick=0, err=0, busy=0.
- A reset asserted mid-transaction aborts immediately. ss_n releases asynchronously and no partial data is latched.
- Poll counter runs continuously, 0..POLL_DIV-1, and wraps. The wrap cycle is the "slot".
- Arbitration at a slot while in IDLE:
  - If en[rr]=1, serve rr.
  - Else if en[~rr]=1, serve ~rr.
  - Else stay in IDLE.
  - After serving player p, rr=~p.
  - A slot that arrives while not in IDLE is dropped, not queued.
- States:
  - IDLE: wait for a slot with a grant. Latch sel = granted player, clear byte index k, go to SEL.
  - SEL: ss_n[sel]=0, the other bit stays 1. Count SETTLE cycles, then go to REQ.
  - REQ: pulse byte_req one cycle. byte_tx = k==0 ? {6'b100000, led_sel} : 8'h00. Go to WAIT.
  - WAIT: wait for byte_done, store byte_rx into shadow[k].
    - If k<4: k++, go to GAP.
    - If k==4: go to DONE.
    - If TIMEOUT cycles elapse with no byte_done: err[sel]<=1, go to ABORT.
  - GAP: count SETTLE cycles, then go to REQ.
  - DONE (1 cycle): ss_n=2'b11. For player sel, latch in parallel:
    - x = {shadow[1][1:0], shadow[0]}
    - y = {shadow[3][1:0], shadow[2]}
    - btn = shadow[4][2:0]
    - pulse cursor_tick[sel] for exactly this cycle.
    - Go to IDLE.
  - ABORT (1 cycle): ss_n=2'b11; outputs unchanged; no tick; go to IDLE.
- Outputs are registered. The cycle after DONE, joy/btn hold the new values. cursor_tick is high in the DONE cycle, i.e. the outputs update on the same edge that raises the tick.
- A byte_done arriving outside WAIT is ignored.
- en[sel] deasserting mid-transaction does not abort; the transaction completes.
- At most one ss_n bit is low at any time.
- err bits clear only on reset.

Optional Feature:
- Macro: JOY_DEADZONE_EN.
- When defined: at DONE, any axis value v with 512-DZ <= v <= 512+DZ is latched as 512. Other values pass unchanged, so the cursor does not drift at rest.
- When undefined: raw values are latched and DZ is unused.

Test Plan:
- Reset, en=2'b11. Engine model returns 0x34,0x02,0xC8,0x01,0x05 to P1. Expect:
  - ss_n=2'b10 during the transaction.
  - First byte_tx=0x80|led1; remaining byte_tx=0x00.
  - joy1_x=0x234, joy1_y=0x1C8, btn1=3'b101.
  - One cursor_tick[0] pulse; joy2 stays 512.
- en=2'b11 over four slots: served order is P1,P2,P1,P2, and cursor_tick alternates bits. With en=2'b10, every slot serves P2.
- Suppress byte_done after byte 2:
  - After TIMEOUT cycles, err[sel]=1, ss_n=2'b11, no tick, previous joy values retained.
  - Next slot serves the other player.
- Assert clr_n=0 in WAIT, byte 3: same cycle ss_n=2'b11 and all outputs return to reset values; after release, the first grant goes to P1.
- Set POLL_DIV smaller than one transaction length: overlapping slots are dropped and busy never deasserts between DONE and a new SEL within one cycle of DONE.
- With JOY_DEADZONE_EN and DZ=40:
  - x=540 latches 512; x=553 latches 553.
  - Without the macro, x=540 latches 540.
